// File: rtl/t_counter_n.sv
// Modulo-MODULUS up/down counter built from T-type state bits, with load,
// toggle-mask and clear modes plus Tc/Wrap/Err flags for cascading.

module t_counter_n_tbit #(
  parameter logic RST_BIT = 1'b0
) (
  input  logic Clk,
  input  logic Rst,
  input  logic T,
  output logic Q
);
  logic q_q;

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) q_q <= RST_BIT;
    else     q_q <= q_q ^ T;
  end

  assign Q = q_q;
endmodule

module t_counter_n #(
  parameter int WIDTH       = 4,
  parameter int MODULUS     = 16,
  parameter int RESET_VALUE = 0
) (
  input  logic             Clk,
  input  logic             Rst,
  input  logic             En,
  input  logic [1:0]       Mode,
  input  logic             Up,
  input  logic [WIDTH-1:0] Din,
  output logic [WIDTH-1:0] Q,
  output logic             Tc,
  output logic             Wrap,
  output logic             Err
);
  typedef enum logic [1:0] {
    M_COUNT  = 2'b00,
    M_LOAD   = 2'b01,
    M_TOGGLE = 2'b10,
    M_CLEAR  = 2'b11
  } mode_e;

  // MODULUS may equal 2**WIDTH, so range checks use one extra bit.
  localparam logic [WIDTH:0]   MOD_W = (WIDTH+1)'(MODULUS);
  localparam logic [WIDTH-1:0] MAX_V = WIDTH'(MODULUS - 1);
  localparam logic [WIDTH-1:0] RST_V = WIDTH'(RESET_VALUE);

  logic [WIDTH-1:0] q_q, q_d, t_vec, mask_r;
  logic             wrap_q, wrap_d, err_q, err_d;
  logic             at_max, at_min;

  assign at_max = (q_q == MAX_V);
  assign at_min = (q_q == '0);
  assign mask_r = q_q ^ Din;

  always_comb begin
    q_d    = q_q;
    wrap_d = 1'b0;
    err_d  = err_q;
    if (En) begin
      unique case (mode_e'(Mode))
        M_COUNT: begin
          if (Up) begin
            if (at_max) begin q_d = '0; wrap_d = 1'b1; end
            else        q_d = q_q + WIDTH'(1);
          end else begin
            if (at_min) begin q_d = MAX_V; wrap_d = 1'b1; end
            else        q_d = q_q - WIDTH'(1);
          end
        end
        M_LOAD: begin
          if ({1'b0, Din} < MOD_W) q_d = Din;
          else begin q_d = '0; err_d = 1'b1; end
        end
        M_TOGGLE: begin
          if ({1'b0, mask_r} < MOD_W) q_d = mask_r;
          else begin q_d = '0; err_d = 1'b1; end
        end
        M_CLEAR: begin
          q_d   = '0;
          err_d = 1'b0;
        end
        default: q_d = q_q;
      endcase
    end
  end

  // Each state bit flips only where the next state differs; all-zero when En=0.
  assign t_vec = q_q ^ q_d;

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    t_counter_n_tbit #(.RST_BIT(RST_V[i])) u_bit (
      .Clk (Clk),
      .Rst (Rst),
      .T   (t_vec[i]),
      .Q   (q_q[i])
    );
  end

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      wrap_q <= 1'b0;
      err_q  <= 1'b0;
    end else begin
      wrap_q <= wrap_d;
      err_q  <= err_d;
    end
  end

  assign Tc   = En & (Mode == 2'b00) & ((Up & at_max) | (~Up & at_min));
  assign Q    = q_q;
  assign Wrap = wrap_q;
  assign Err  = err_q;
endmodule

// File: tb/tb_t_counter_n.sv
// Self-checking bench for t_counter_n: directed scenarios, a two-stage
// cascade, and randomized traffic against an arithmetic reference model.

module tb_t_counter_n;
  logic       Clk;
  logic       Rst, En, Up;
  logic [1:0] Mode;
  logic [3:0] Din;
  logic [3:0] q10, q16;
  logic       tc10, wrap10, err10, tc16, wrap16, err16;

  logic       c_rst, c_en;
  logic [3:0] lo_q, hi_q;
  logic       lo_tc, lo_wrap, lo_err, hi_tc, hi_wrap, hi_err;

  int checks = 0;
  int errors = 0;

  t_counter_n #(.WIDTH(4), .MODULUS(10), .RESET_VALUE(3)) dut (
    .Clk(Clk), .Rst(Rst), .En(En), .Mode(Mode), .Up(Up), .Din(Din),
    .Q(q10), .Tc(tc10), .Wrap(wrap10), .Err(err10));

  t_counter_n #(.WIDTH(4), .MODULUS(16), .RESET_VALUE(5)) dut16 (
    .Clk(Clk), .Rst(Rst), .En(En), .Mode(Mode), .Up(Up), .Din(Din),
    .Q(q16), .Tc(tc16), .Wrap(wrap16), .Err(err16));

  t_counter_n #(.WIDTH(4), .MODULUS(10), .RESET_VALUE(0)) u_lo (
    .Clk(Clk), .Rst(c_rst), .En(c_en), .Mode(2'b00), .Up(1'b1), .Din(4'd0),
    .Q(lo_q), .Tc(lo_tc), .Wrap(lo_wrap), .Err(lo_err));

  t_counter_n #(.WIDTH(4), .MODULUS(10), .RESET_VALUE(0)) u_hi (
    .Clk(Clk), .Rst(c_rst), .En(lo_tc), .Mode(2'b00), .Up(1'b1), .Din(4'd0),
    .Q(hi_q), .Tc(hi_tc), .Wrap(hi_wrap), .Err(hi_err));

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  // Advance past one rising edge; outputs are sampled 1 time unit later.
  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic drive(input bit en, input logic [1:0] mode, input bit up, input logic [3:0] din);
    En = en; Mode = mode; Up = up; Din = din;
  endtask

  task automatic test_reset();
    Rst = 1'b1; drive(0, 2'b00, 1, 0);
    tick();
    Rst = 1'b0;
    checks++; if ({q10, wrap10, err10} !== {4'd3, 1'b0, 1'b0}) begin
      errors++; $display("FAIL reset_state got q=%0d w=%0b e=%0b exp q=3 w=0 e=0", q10, wrap10, err10); end
    drive(1, 2'b01, 1, 4'd12);
    tick();
    drive(1, 2'b00, 1, 0);
    repeat (7) tick();
    checks++; if ({q10, err10} !== {4'd7, 1'b1}) begin
      errors++; $display("FAIL pre_reset got q=%0d e=%0b exp q=7 e=1", q10, err10); end
    #2 Rst = 1'b1;
    #1;
    checks++; if ({q10, wrap10, err10} !== {4'd3, 1'b0, 1'b0}) begin
      errors++; $display("FAIL async_reset got q=%0d w=%0b e=%0b exp q=3 w=0 e=0", q10, wrap10, err10); end
    tick(); tick();
    checks++; if (q10 !== 4'd3) begin
      errors++; $display("FAIL reset_hold got q=%0d exp 3", q10); end
    Rst = 1'b0;
  endtask

  task automatic test_up_wrap();
    drive(1, 2'b11, 1, 0);
    tick();
    drive(1, 2'b00, 1, 0);
    for (int i = 1; i <= 10; i++) begin
      #1;
      checks++; if (tc10 !== (i == 10)) begin
        errors++; $display("FAIL up_tc step=%0d got %0b exp %0b", i, tc10, (i == 10)); end
      tick();
      checks++; if ({q10, wrap10} !== {4'(i % 10), (i == 10)}) begin
        errors++; $display("FAIL up_count step=%0d got q=%0d w=%0b exp q=%0d w=%0b", i, q10, wrap10, i % 10, (i == 10)); end
    end
  endtask

  task automatic test_down_hold();
    drive(1, 2'b00, 0, 0);
    #1;
    checks++; if (tc10 !== 1'b1) begin
      errors++; $display("FAIL down_tc got %0b exp 1", tc10); end
    tick();
    checks++; if ({q10, wrap10} !== {4'd9, 1'b1}) begin
      errors++; $display("FAIL down_wrap got q=%0d w=%0b exp q=9 w=1", q10, wrap10); end
    drive(0, 2'b00, 1, 0);
    #1;
    checks++; if (tc10 !== 1'b0) begin
      errors++; $display("FAIL hold_tc got %0b exp 0", tc10); end
    repeat (3) tick();
    checks++; if ({q10, wrap10, tc10} !== {4'd9, 1'b0, 1'b0}) begin
      errors++; $display("FAIL hold got q=%0d w=%0b tc=%0b exp q=9 w=0 tc=0", q10, wrap10, tc10); end
  endtask

  task automatic test_load_err();
    drive(1, 2'b01, 1, 4'd6); tick();
    checks++; if ({q10, err10} !== {4'd6, 1'b0}) begin
      errors++; $display("FAIL load6 got q=%0d e=%0b exp q=6 e=0", q10, err10); end
    drive(1, 2'b01, 1, 4'd12); tick();
    checks++; if ({q10, err10} !== {4'd0, 1'b1}) begin
      errors++; $display("FAIL load12 got q=%0d e=%0b exp q=0 e=1", q10, err10); end
    drive(1, 2'b00, 1, 0); tick(); tick();
    checks++; if ({q10, err10} !== {4'd2, 1'b1}) begin
      errors++; $display("FAIL err_sticky got q=%0d e=%0b exp q=2 e=1", q10, err10); end
    drive(1, 2'b11, 1, 0); tick();
    checks++; if ({q10, err10} !== {4'd0, 1'b0}) begin
      errors++; $display("FAIL clear got q=%0d e=%0b exp q=0 e=0", q10, err10); end
  endtask

  task automatic test_toggle();
    drive(1, 2'b01, 1, 4'd5); tick();
    drive(1, 2'b10, 1, 4'b0011); tick();
    checks++; if (q10 !== 4'd6) begin
      errors++; $display("FAIL tog_0011 got q=%0d exp 6", q10); end
    drive(1, 2'b10, 1, 4'b0000); tick();
    checks++; if ({q10, err10} !== {4'd6, 1'b0}) begin
      errors++; $display("FAIL tog_zero got q=%0d e=%0b exp q=6 e=0", q10, err10); end
    drive(1, 2'b10, 1, 4'b1000); tick();
    checks++; if ({q10, err10} !== {4'd0, 1'b1}) begin
      errors++; $display("FAIL tog_range got q=%0d e=%0b exp q=0 e=1", q10, err10); end
    drive(1, 2'b11, 1, 0); tick();
  endtask

  task automatic test_cascade();
    int wraps = 0;
    c_en = 1'b0; c_rst = 1'b1; tick(); c_rst = 1'b0;
    c_en = 1'b1;
    for (int i = 1; i <= 100; i++) begin
      tick();
      if (hi_wrap) wraps++;
      checks++; if (int'(hi_q) * 10 + int'(lo_q) !== i % 100) begin
        errors++; $display("FAIL cascade step=%0d got %0d%0d exp %0d", i, hi_q, lo_q, i % 100); end
    end
    c_en = 1'b0;
    tick();
    if (hi_wrap) wraps++;
    checks++; if (wraps !== 1) begin
      errors++; $display("FAIL cascade_wrap got %0d pulses exp 1", wraps); end
    checks++; if ({lo_err, hi_err} !== 2'b00) begin
      errors++; $display("FAIL cascade_err got %b exp 00", {lo_err, hi_err}); end
  endtask

  // Reference model: the counter is an integer in 0..m-1 advanced with modular arithmetic.
  task automatic model_step(input int m, input int rv, input bit rst, input bit en,
                            input logic [1:0] mode, input bit up, input int din,
                            inout int q, inout int w, inout int e);
    int r;
    w = 0;
    if (rst) begin q = rv; e = 0; end
    else if (en) begin
      case (mode)
        2'b00: if (up) begin w = (q == m - 1); q = (q + 1) % m; end
               else    begin w = (q == 0);     q = (q + m - 1) % m; end
        2'b01: if (din < m) q = din; else begin q = 0; e = 1; end
        2'b10: begin r = q ^ din; if (r < m) q = r; else begin q = 0; e = 1; end end
        default: begin q = 0; e = 0; end
      endcase
    end
  endtask

  task automatic test_random();
    int qa, wa, ea, qb, wb, eb;
    bit rst_r, exp_tc;
    drive(1, 2'b11, 1, 0); tick();
    qa = 0; wa = 0; ea = 0; qb = 0; wb = 0; eb = 0;
    for (int n = 0; n < 400; n++) begin
      rst_r = ($urandom_range(0, 49) == 0);
      drive(($urandom_range(0, 5) != 0), 2'($urandom_range(0, 3) == 3 ? $urandom_range(0, 3)
            : $urandom_range(0, 2) == 0 ? 2'($urandom_range(1, 2)) : 2'b00),
            1'($urandom), 4'($urandom));
      Rst = rst_r;
      if (!rst_r) begin
        #1;
        exp_tc = En && Mode == 2'b00 && (Up ? qa == 9 : qa == 0);
        checks++; if (tc10 !== exp_tc) begin
          errors++; $display("FAIL rnd_tc10 n=%0d got %0b exp %0b", n, tc10, exp_tc); end
        exp_tc = En && Mode == 2'b00 && (Up ? qb == 15 : qb == 0);
        checks++; if (tc16 !== exp_tc) begin
          errors++; $display("FAIL rnd_tc16 n=%0d got %0b exp %0b", n, tc16, exp_tc); end
      end
      model_step(10, 3, rst_r, En, Mode, Up, int'(Din), qa, wa, ea);
      model_step(16, 5, rst_r, En, Mode, Up, int'(Din), qb, wb, eb);
      tick();
      Rst = 1'b0;
      checks++; if ({q10, wrap10, err10} !== {4'(qa), 1'(wa), 1'(ea)}) begin
        errors++; $display("FAIL rnd_m10 n=%0d got q=%0d w=%0b e=%0b exp q=%0d w=%0d e=%0d", n, q10, wrap10, err10, qa, wa, ea); end
      checks++; if ({q16, wrap16, err16} !== {4'(qb), 1'(wb), 1'b0}) begin
        errors++; $display("FAIL rnd_m16 n=%0d got q=%0d w=%0b e=%0b exp q=%0d w=%0d e=0", n, q16, wrap16, err16, qb, wb); end
    end
  endtask

  initial begin
    Rst = 1'b0; c_rst = 1'b1; c_en = 1'b0;
    drive(0, 2'b00, 1, 0);
    #2;
    test_reset();
    test_up_wrap();
    test_down_hold();
    test_load_err();
    test_toggle();
    test_cascade();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
